// File: rtl/servo_move_if.sv
// servo_move_if: MBED request channel and PWM move-command channel of the servo scheduler.
interface servo_move_if;
    logic       req_valid;
    logic [1:0] req_pos;
    logic       req_ready;
    logic       req_err;
    logic       move_valid;
    logic       move_dir;
    logic [7:0] move_frames;
    logic       move_ready;
    logic       move_done;
    logic [1:0] cur_pos;
    logic       busy;
    modport master (
        output req_valid, req_pos, move_ready, move_done,
        input  req_ready, req_err, move_valid, move_dir, move_frames, cur_pos, busy
    );
    modport slave (
        input  req_valid, req_pos, move_ready, move_done,
        output req_ready, req_err, move_valid, move_dir, move_frames, cur_pos, busy
    );
endinterface

// File: rtl/servo_move_scheduler.sv
// servo_move_scheduler: queues servo position requests and issues one PWM move at a time.
// Define SERVO_SCHED_COALESCE_EN to drop requests equal to the latest reference position.
module servo_move_scheduler #(
    parameter int         FIFO_DEPTH      = 4,
    parameter int         FRAMES_PER_STEP = 14,
    parameter int         SETTLE_TICKS    = 500000,
    parameter logic [1:0] HOME_POS        = 2'd0
) (
    input logic       clk,
    input logic       rst_n,
    servo_move_if.slave bus
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = SETTLE_TICKS > 1 ? $clog2(SETTLE_TICKS) : 1;
    localparam int SM1 = SETTLE_TICKS - 1;
    localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
    localparam logic [7:0]  FPS  = FRAMES_PER_STEP[7:0];
    typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT, SETTLE} state_t;
    state_t        state;
    logic [1:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr, rd;
    logic [AW:0]   count, count_nx;
    logic [1:0]    target, diff;
    logic [CW-1:0] settle;
    logic          accept, push, pop, dup;
`ifdef SERVO_SCHED_COALESCE_EN
    logic [AW-1:0] last;
    assign last = wr - AW'(1);
`endif
    always_comb begin
        accept = bus.req_valid && bus.req_ready;
`ifdef SERVO_SCHED_COALESCE_EN
        // newest queued entry, else in-flight target, else the settled position
        dup = bus.req_pos == (|count ? mem[last] : state != IDLE ? target : bus.cur_pos);
`else
        dup = 1'b0;
`endif
        push = accept && bus.req_pos != 2'd3 && !dup;
        pop = state == IDLE && |count;
        count_nx = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        diff = target > bus.cur_pos ? target - bus.cur_pos : bus.cur_pos - target;
    end
    assign bus.busy = state != IDLE || |count;
    always_ff @(posedge clk)
        if (push) mem[wr] <= bus.req_pos;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            wr              <= '0;
            rd              <= '0;
            count           <= '0;
            target          <= HOME_POS;
            settle          <= '0;
            bus.req_ready   <= 1'b1;
            bus.req_err     <= 1'b0;
            bus.move_valid  <= 1'b0;
            bus.move_dir    <= 1'b0;
            bus.move_frames <= '0;
            bus.cur_pos     <= HOME_POS;
        end else begin
            count         <= count_nx;
            bus.req_ready <= count_nx != FULL;
            bus.req_err   <= accept && bus.req_pos == 2'd3;
            if (push) wr <= wr + AW'(1);
            if (pop) rd <= rd + AW'(1);
            case (state)
                IDLE: if (pop) begin
                    target <= mem[rd];
                    state  <= CALC;
                end
                CALC: if (target == bus.cur_pos) state <= IDLE;
                else begin
                    bus.move_dir    <= target > bus.cur_pos;
                    bus.move_frames <= FPS * {6'd0, diff};
                    bus.move_valid  <= 1'b1;
                    state           <= ISSUE;
                end
                ISSUE: if (bus.move_ready) begin
                    bus.move_valid <= 1'b0;
                    state          <= WAIT;
                end
                WAIT: if (bus.move_done) begin
                    bus.cur_pos <= target;
                    settle      <= SM1[CW-1:0];
                    state       <= SETTLE;
                end
                SETTLE: if (settle == '0) state <= IDLE;
                else settle <= settle - CW'(1);
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_servo_move_scheduler.sv
// tb_servo_move_scheduler: randomized scoreboard bench with a position-level reference model.
module tb_servo_move_scheduler;
    localparam int SETTLE = 8;
    localparam int FPS    = 14;
    typedef struct {
        logic [1:0] tgt;
        logic       dir;
        int         frames;
    } cmd_t;
    logic clk, rst_n;
    servo_move_if bus();
    servo_move_scheduler #(
        .FIFO_DEPTH(4), .FRAMES_PER_STEP(FPS), .SETTLE_TICKS(SETTLE), .HOME_POS(2'd0)
    ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int checks = 0, failures = 0, cyc = 0, n_cmds = 0;
    bit ready_en = 0, done_en = 1, stray = 0;
    cmd_t expq[$];
    cmd_t mc, pc;
    logic [1:0] mcur = 0, plan = 0, out_tgt = 0;
    bit outst = 0, pend = 0, err_exp = 0;
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask
    task automatic timeout(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask
    // Monitor: a command is a high-level "move to tgt"; its dir/frames follow from the planned position.
    always @(negedge clk) begin
        if (!rst_n) begin
            expq.delete();
            outst = 0; pend = 0; err_exp = 0; mcur = 0; plan = 0;
        end else begin
            check("cur_pos", bus.cur_pos, mcur);
            check("req_err", bus.req_err, err_exp);
            if (pend) begin
                check("hold_valid", bus.move_valid, 1);
                check("hold_dir", bus.move_dir, pc.dir);
                check("hold_frames", bus.move_frames, pc.frames);
            end
            pend = 0;
            if (bus.move_valid && bus.move_ready) begin
                n_cmds++;
                if (expq.size() == 0) timeout("unexpected_cmd");
                else begin
                    mc = expq.pop_front();
                    check("cmd_dir", bus.move_dir, mc.dir);
                    check("cmd_frames", bus.move_frames, mc.frames);
                    out_tgt = mc.tgt;
                    outst = 1;
                end
            end else if (bus.move_valid) begin
                pend = 1;
                pc.dir = bus.move_dir;
                pc.frames = bus.move_frames;
            end
            if (bus.move_done && outst) begin
                mcur = out_tgt;
                outst = 0;
            end
            err_exp = bus.req_valid && bus.req_ready && bus.req_pos == 2'd3;
            if (bus.req_valid && bus.req_ready && bus.req_pos != 2'd3 && bus.req_pos != plan) begin
                mc.tgt = bus.req_pos;
                mc.dir = bus.req_pos > plan;
                mc.frames = (int'(bus.req_pos) > int'(plan) ? int'(bus.req_pos) - int'(plan)
                                                            : int'(plan) - int'(bus.req_pos)) * FPS;
                expq.push_back(mc);
                plan = bus.req_pos;
            end
        end
    end
    // PWM generator model: random ready, move_done 1..4 cycles after each accepted command.
    initial begin
        bit hs;
        int wait_n = 0;
        bus.move_ready = 0;
        bus.move_done = 0;
        forever begin
            @(negedge clk);
            hs = bus.move_valid && bus.move_ready && rst_n;
            @(posedge clk); #1;
            bus.move_done = 0;
            if (!rst_n) wait_n = 0;
            else if (hs) wait_n = int'($urandom_range(1, 4));
            else if (wait_n > 0) begin
                wait_n--;
                if (wait_n == 0 && done_en) bus.move_done = 1;
            end else if (stray) begin
                bus.move_done = 1;
                stray = 0;
            end
            bus.move_ready = ready_en && ($urandom_range(0, 2) != 0);
        end
    end
    task automatic push(input logic [1:0] p);
        int n = 0;
        bus.req_valid = 1;
        bus.req_pos = p;
        @(negedge clk);
        while (!bus.req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout("push");
        @(posedge clk); #1;
        bus.req_valid = 0;
    endtask
    task automatic wait_valid(input logic lvl);
        int n = 0;
        @(negedge clk);
        while (bus.move_valid !== lvl && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout("wait_valid");
    endtask
    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (bus.busy && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout("wait_idle");
        @(posedge clk); #1;
    endtask
    initial begin
        int n0, n;
        rst_n = 0;
        bus.req_valid = 0;
        bus.req_pos = 0;
        repeat (3) @(negedge clk);
        check("rst_move_valid", bus.move_valid, 0);
        check("rst_move_dir", bus.move_dir, 0);
        check("rst_move_frames", bus.move_frames, 0);
        check("rst_req_err", bus.req_err, 0);
        check("rst_cur_pos", bus.cur_pos, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_req_ready", bus.req_ready, 1);
        #2 rst_n = 1;
        @(posedge clk); #1;
        // first move 0->2: latency, hold while move_ready low
        push(2);
        n0 = cyc;
        wait_valid(1);
        check("latency", cyc - n0, 2);
        repeat (5) @(negedge clk);
        check("held_valid", bus.move_valid, 1);
        ready_en = 1;
        wait_idle();
        check("pos_after_first", bus.cur_pos, 2);
        // 2->0 then 0->1; second command spaced by the settle interval
        push(0);
        push(1);
        n = 0;
        @(negedge clk);
        while (!bus.move_done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) timeout("first_done");
        n0 = cyc + 1;
        wait_valid(1);
        check("settle_gap", cyc - n0, SETTLE + 2);
        wait_idle();
        check("pos_after_pair", bus.cur_pos, 1);
        // fill the queue while the FSM is stuck in ISSUE
        ready_en = 0;
        push(2);
        wait_valid(1);
        @(posedge clk); #1;
        push(0); push(2); push(0); push(1);
        @(negedge clk);
        check("full_ready", bus.req_ready, 0);
        @(posedge clk); #1;
        bus.req_valid = 1;
        bus.req_pos = 2;
        repeat (3) begin
            @(negedge clk);
            check("full_refuse", bus.req_ready, 0);
        end
        @(posedge clk); #1;
        bus.req_valid = 0;
        ready_en = 1;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("ready_back", bus.req_ready, 1);
        wait_idle();
        check("pos_after_fill", bus.cur_pos, 1);
        // invalid position
        push(3);
        @(negedge clk);
        check("err_pulse", bus.req_err, 1);
        check("err_not_busy", bus.busy, 0);
        @(negedge clk);
        check("err_one_cycle", bus.req_err, 0);
        @(posedge clk); #1;
        // reset during WAIT, then a stray move_done
        done_en = 0;
        push(2);
        wait_valid(1);
        wait_valid(0);
        #2 rst_n = 0;
        #1;
        check("midrst_valid", bus.move_valid, 0);
        check("midrst_cur_pos", bus.cur_pos, 0);
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1;
        @(posedge clk); #1;
        done_en = 1;
        stray = 1;
        repeat (10) @(negedge clk);
        check("stray_cur_pos", bus.cur_pos, 0);
        check("stray_busy", bus.busy, 0);
        @(posedge clk); #1;
        // randomized traffic
        repeat (40) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
            end
            push(2'($urandom_range(0, 3)));
        end
        wait_idle();
        check("rand_drained", expq.size(), 0);
        // duplicate requests collapse to one command
        push(0);
        wait_idle();
        n0 = n_cmds;
        push(1); push(1); push(1);
        wait_idle();
        check("dup_cmds", n_cmds - n0, 1);
        check("dup_cur_pos", bus.cur_pos, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
